// File: rtl/puf_ro_evaluator.sv
// Ring-oscillator PUF evaluation engine: timed RO-pair comparisons packed into response bytes.
// Optional macro PUF_MAJORITY_VOTE_EN: each bit is the 2-of-3 majority of three identical passes.
module puf_ro_evaluator #(
    parameter int unsigned RESP_WORDS    = 4,
    parameter int unsigned EVAL_CYCLES   = 1024,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   puf_reset,
    input  logic                   puf_enable,
    input  logic [7:0]             challenge,
    input  logic [COUNT_WIDTH-1:0] count_a,
    input  logic [COUNT_WIDTH-1:0] count_b,
    input  logic                   fifo_full,
    output logic [3:0]             ro_sel_a,
    output logic [3:0]             ro_sel_b,
    output logic                   ro_en,
    output logic                   ro_clear,
    output logic                   fifo_we,
    output logic [7:0]             fifo_din,
    output logic                   puf_done
);

    localparam int unsigned TimerMax = (EVAL_CYCLES > SETTLE_CYCLES) ? EVAL_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);
    localparam logic [7:0]  LastK    = 8'(RESP_WORDS * 8);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StSettle,
        StCompare,
        StWrite,
        StDone,
        StRearm
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        chal_q, chal_d;
    logic [7:0]        k_q, k_d;
    logic [7:0]        shift_q, shift_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [3:0]        sel_a_q, sel_a_d;
    logic [3:0]        sel_b_q, sel_b_d;
    logic              ro_en_q, ro_en_d;
    logic              ro_clear_q, ro_clear_d;
    logic              fifo_we_q, fifo_we_d;
    logic [7:0]        fifo_din_q, fifo_din_d;
    logic              puf_done_q, puf_done_d;
    logic              cmp;
    logic              commit;
    logic              bit_val;
`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0]        pass_q, pass_d;
    logic [1:0]        votes_q, votes_d;
`endif

    assign cmp = (count_a > count_b);

    always_comb begin
        state_d    = state_q;
        chal_d     = chal_q;
        k_d        = k_q;
        shift_d    = shift_q;
        timer_d    = timer_q;
        sel_a_d    = sel_a_q;
        sel_b_d    = sel_b_q;
        fifo_din_d = fifo_din_q;
        fifo_we_d  = 1'b0;
        commit     = 1'b0;
        bit_val    = 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
        pass_d     = pass_q;
        votes_d    = votes_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (puf_enable) begin
                    chal_d  = challenge;
                    k_d     = 8'd0;
                    shift_d = 8'd0;
`ifdef PUF_MAJORITY_VOTE_EN
                    pass_d  = 2'd0;
                    votes_d = 2'd0;
`endif
                    state_d = StClear;
                end
            end
            StClear: begin
                timer_d = TimerW'(EVAL_CYCLES - 1);
                state_d = StRun;
            end
            StRun: begin
                if (timer_q == '0) begin
                    timer_d = TimerW'(SETTLE_CYCLES - 1);
                    state_d = StSettle;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StSettle: begin
                if (timer_q == '0) begin
                    state_d = StCompare;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StCompare: begin
`ifdef PUF_MAJORITY_VOTE_EN
                if (pass_q == 2'd2) begin
                    commit  = 1'b1;
                    bit_val = (({1'b0, votes_q} + {2'b00, cmp}) >= 3'd2);
                    pass_d  = 2'd0;
                    votes_d = 2'd0;
                end else begin
                    pass_d  = pass_q + 2'd1;
                    votes_d = votes_q + {1'b0, cmp};
                    state_d = StClear;
                end
`else
                commit  = 1'b1;
                bit_val = cmp;
`endif
                if (commit) begin
                    shift_d = {shift_q[6:0], bit_val};
                    k_d     = k_q + 8'd1;
                    if (k_d[2:0] == 3'd0) begin
                        // fifo_full is sampled one cycle ahead so the strobe can be registered
                        fifo_we_d = ~fifo_full;
                        state_d   = StWrite;
                    end else begin
                        state_d = StClear;
                    end
                end
            end
            StWrite: begin
                if (fifo_we_q) begin
                    state_d = (k_q == LastK) ? StDone : StClear;
                end else begin
                    fifo_we_d = ~fifo_full;
                end
            end
            StDone: begin
                state_d = StRearm;
            end
            StRearm: begin
                if (!puf_enable) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered, so decode them from the next state.
        ro_en_d    = (state_d == StRun);
        ro_clear_d = (state_d == StClear);
        puf_done_d = (state_d == StDone);
        if (state_d == StClear) begin
            sel_a_d = chal_d[3:0] + k_d[3:0];
            sel_b_d = sel_a_d ^ (chal_d[7:4] | 4'b0001);
        end
        if (fifo_we_d) begin
            fifo_din_d = shift_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || puf_reset) begin
            state_q    <= StIdle;
            chal_q     <= 8'd0;
            k_q        <= 8'd0;
            shift_q    <= 8'd0;
            timer_q    <= '0;
            sel_a_q    <= 4'd0;
            sel_b_q    <= 4'd0;
            ro_en_q    <= 1'b0;
            ro_clear_q <= 1'b0;
            fifo_we_q  <= 1'b0;
            fifo_din_q <= 8'd0;
            puf_done_q <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
            pass_q     <= 2'd0;
            votes_q    <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            chal_q     <= chal_d;
            k_q        <= k_d;
            shift_q    <= shift_d;
            timer_q    <= timer_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            ro_en_q    <= ro_en_d;
            ro_clear_q <= ro_clear_d;
            fifo_we_q  <= fifo_we_d;
            fifo_din_q <= fifo_din_d;
            puf_done_q <= puf_done_d;
`ifdef PUF_MAJORITY_VOTE_EN
            pass_q     <= pass_d;
            votes_q    <= votes_d;
`endif
        end
    end

    assign ro_sel_a = sel_a_q;
    assign ro_sel_b = sel_b_q;
    assign ro_en    = ro_en_q;
    assign ro_clear = ro_clear_q;
    assign fifo_we  = fifo_we_q;
    assign fifo_din = fifo_din_q;
    assign puf_done = puf_done_q;

endmodule

// File: tb/tb_puf_ro_evaluator.sv
// Self-checking bench for puf_ro_evaluator: randomized RO frequencies against a byte-level model.
module tb_puf_ro_evaluator;

    localparam int unsigned RW = 2;
    localparam int unsigned EC = 16;
    localparam int unsigned SC = 4;
    localparam int unsigned CW = 16;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int unsigned Passes = 3;
`else
    localparam int unsigned Passes = 1;
`endif
    localparam int unsigned TBit   = Passes * (EC + SC + 2);
    localparam int unsigned RunLen = 1 + RW * (8 * TBit + 1);

    logic          clk = 1'b0;
    logic          reset, puf_reset, puf_enable, fifo_full;
    logic [7:0]    challenge;
    logic [CW-1:0] count_a, count_b;
    logic [3:0]    ro_sel_a, ro_sel_b;
    logic          ro_en, ro_clear, fifo_we, puf_done;
    logic [7:0]    fifo_din;

    puf_ro_evaluator #(
        .RESP_WORDS   (RW),
        .EVAL_CYCLES  (EC),
        .SETTLE_CYCLES(SC),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .puf_reset (puf_reset),
        .puf_enable(puf_enable),
        .challenge (challenge),
        .count_a   (count_a),
        .count_b   (count_b),
        .fifo_full (fifo_full),
        .ro_sel_a  (ro_sel_a),
        .ro_sel_b  (ro_sel_b),
        .ro_en     (ro_en),
        .ro_clear  (ro_clear),
        .fifo_we   (fifo_we),
        .fifo_din  (fifo_din),
        .puf_done  (puf_done)
    );

    initial forever #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned freq[16];
    int unsigned mode, const_a, const_b;
    bit          flip_p2;
    int unsigned clears = 0, clears_base = 0, overlap = 0;
    int unsigned full_lo = 0, full_hi = 0, noise_lo = 0, noise_hi = 0;
    int unsigned wr_cyc[$];
    logic [7:0]  wr_dat[$];
    int unsigned done_cyc[$];
    logic [7:0]  sel_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count an RO would produce: either one constant pair for all ROs, or a per-RO frequency.
    function automatic int unsigned cnt_of(input int unsigned sel, input bit is_a);
        if (mode == 1) return is_a ? const_a : const_b;
        return freq[sel];
    endfunction

    function automatic logic [7:0] exp_byte(input logic [7:0] chal, input int unsigned j);
        logic [7:0] r = 8'd0;
        for (int b = 0; b < 8; b++) begin
            int unsigned k  = 8 * j + b;
            int unsigned sa = ((chal & 8'h0f) + k) % 16;
            int unsigned sb = sa ^ (((chal >> 4) & 15) | 1);
            if (cnt_of(sa, 1'b1) > cnt_of(sb, 1'b0)) r[7-b] = 1'b1;
        end
        return r;
    endfunction

    // Environment: RO counts follow the selects; fifo_full follows the stall/noise windows.
    initial begin
        int unsigned a, b, t, pass;
        fifo_full = 1'b0;
        count_a   = '0;
        count_b   = '0;
        forever begin
            @(posedge clk);
            #1;
            fifo_full = (cyc >= full_lo && cyc < full_hi) ||
                        (cyc >= noise_lo && cyc < noise_hi && $urandom_range(0, 1) == 1);
            pass = (clears > clears_base) ? (clears - clears_base - 1) % Passes : 0;
            a = cnt_of(ro_sel_a, 1'b1);
            b = cnt_of(ro_sel_b, 1'b0);
            if (flip_p2 && pass == 1) begin
                t = a;
                a = b;
                b = t;
            end
            count_a = CW'(a);
            count_b = CW'(b);
        end
    end

    always @(negedge clk) begin
        if (ro_clear) begin
            clears++;
            sel_log.push_back({ro_sel_a, ro_sel_b});
        end
        if (fifo_we) begin
            wr_cyc.push_back(cyc);
            wr_dat.push_back(fifo_din);
        end
        if (puf_done) done_cyc.push_back(cyc);
        if (fifo_we && puf_done) overlap++;
    end

    task automatic run_case(input logic [7:0] chal, input bit stall, input bit en_drop,
                            input bit flip);
        int unsigned c0, wb, db, cb, sb, ov0, t, add;
        flip_p2     = flip;
        wb          = wr_cyc.size();
        db          = done_cyc.size();
        sb          = sel_log.size();
        cb          = clears;
        ov0         = overlap;
        clears_base = cb;
        challenge   = chal;
        puf_enable  = 1'b1;
        c0          = cyc;
        add         = stall ? 10 : 0;
        full_lo     = stall ? c0 + 8 * TBit : 0;
        full_hi     = stall ? full_lo + 10 : 0;
        noise_lo    = c0 + 2;
        noise_hi    = c0 + 8 * TBit - 2;
        tick();
        challenge = 8'($urandom);
        if (en_drop) puf_enable = 1'b0;
        t = 0;
        while (done_cyc.size() == db && t < RunLen + 40) begin
            tick();
            t++;
        end
        if (done_cyc.size() == db) check_val("done_timeout", 0, 1);
        else check_val("done_cycle", done_cyc[db] - c0, RunLen + add);
        check_val("num_writes", wr_cyc.size() - wb, RW);
        for (int j = 0; j < RW; j++) begin
            if (wb + j < wr_cyc.size()) begin
                check_val("write_cycle", wr_cyc[wb+j] - c0, (j + 1) * (8 * TBit + 1) + add);
                check_val("write_data", wr_dat[wb+j], exp_byte(chal, j));
            end
        end
        check_val("num_clears", clears - cb, 8 * RW * Passes);
        for (int i = 0; i < 8 * RW * Passes; i++) begin
            if (sb + i < sel_log.size()) begin
                int unsigned k  = i / Passes;
                int unsigned sa = ((chal & 8'h0f) + k) % 16;
                int unsigned sx = sa ^ (((chal >> 4) & 15) | 1);
                check_val("selects", sel_log[sb+i], (sa << 4) | sx);
            end
        end
        check_val("we_done_excl", overlap - ov0, 0);
        if (!en_drop) begin
            repeat (30) tick();
            check_val("no_rerun", clears - cb, 8 * RW * Passes);
        end
        puf_enable = 1'b0;
        tick();
    endtask

    task automatic reset_case();
        int unsigned wb, db;
        wb         = wr_cyc.size();
        db         = done_cyc.size();
        challenge  = 8'($urandom);
        puf_enable = 1'b1;
        tick();
        puf_enable = 1'b0;
        repeat (8) tick();
        check_val("ro_en_before_reset", ro_en, 1);
        puf_reset = 1'b1;
        tick();
        puf_reset = 1'b0;
        check_val("ro_en_after_reset", ro_en, 0);
        repeat (200) tick();
        check_val("reset_no_write", wr_cyc.size() - wb, 0);
        check_val("reset_no_done", done_cyc.size() - db, 0);
        check_val("reset_outputs", {ro_sel_a, ro_sel_b, ro_en, ro_clear, fifo_we, fifo_din, puf_done}, 0);
    endtask

    initial begin
        reset      = 1'b1;
        puf_reset  = 1'b0;
        puf_enable = 1'b0;
        challenge  = 8'd0;
        mode       = 1;
        const_a    = 0;
        const_b    = 0;
        flip_p2    = 1'b0;
        foreach (freq[i]) freq[i] = 0;
        repeat (3) tick();
        check_val("reset_state", {ro_sel_a, ro_sel_b, ro_en, ro_clear, fifo_we, fifo_din, puf_done}, 0);
        reset = 1'b0;
        tick();

        // a > b everywhere, then ties, then alternating bits with a stalled first write.
        const_a = 100;
        const_b = 50;
        run_case(8'h35, 1'b0, 1'b0, 1'b0);
        const_a = 70;
        const_b = 70;
        run_case(8'h35, 1'b0, 1'b0, 1'b0);
        mode = 0;
        foreach (freq[i]) freq[i] = (i % 2 == 1) ? 200 : 100;
        run_case(8'h00, 1'b1, 1'b0, 1'b0);
`ifdef PUF_MAJORITY_VOTE_EN
        mode    = 1;
        const_a = 100;
        const_b = 50;
        run_case(8'h35, 1'b0, 1'b0, 1'b1);
        mode = 0;
`endif
        reset_case();

        for (int n = 0; n < 6; n++) begin
            foreach (freq[i]) freq[i] = $urandom_range(0, 31);
            run_case(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
